// File: rtl/cbus_rr_arbiter.sv
// Merges NUM_CH cache-bus requesters onto one cbus, one locked burst at a time (RR or fixed priority).
// Latency: 1 cycle from request valid to oreq_valid; one guaranteed bubble cycle between bursts.
// Backpressure: oresp_ready/oresp_last pass straight through to the granted channel only. Optional: CBUS_ADDR_XLATE_EN.
module cbus_rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int MODE   = 0,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic                          clk,
    input  logic                          resetn,

    input  logic [NUM_CH-1:0]             ireqs_valid,
    input  logic [NUM_CH-1:0]             ireqs_is_write,
    input  logic [NUM_CH-1:0][1:0]        ireqs_size,
    input  logic [NUM_CH-1:0][31:0]       ireqs_addr,
    input  logic [NUM_CH-1:0][3:0]        ireqs_strobe,
    input  logic [NUM_CH-1:0][31:0]       ireqs_data,
    input  logic [NUM_CH-1:0][3:0]        ireqs_len,

    output logic [NUM_CH-1:0]             iresps_ready,
    output logic [NUM_CH-1:0]             iresps_last,
    output logic [NUM_CH-1:0][31:0]       iresps_data,

    output logic                          oreq_valid,
    output logic                          oreq_is_write,
    output logic [1:0]                    oreq_size,
    output logic [31:0]                   oreq_addr,
    output logic [3:0]                    oreq_strobe,
    output logic [31:0]                   oreq_data,
    output logic [3:0]                    oreq_len,

    input  logic                          oresp_ready,
    input  logic                          oresp_last,
    input  logic [31:0]                   oresp_data,

    output logic                          busy,
    output logic [IDX_W-1:0]              grant_idx
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   grant_nxt;
    logic [IDX_W-1:0]   rr_ptr, rr_nxt;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   scan;
    logic [31:0]        addr_fwd;

    // Scan from the highest priority slot last so the first valid slot wins.
    always_comb begin
        winner = '0;
        scan   = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (MODE == 0) begin
                scan = IDX_W'((int'(rr_ptr) + k) % NUM_CH);
            end else begin
                scan = IDX_W'(k);
            end
            if (ireqs_valid[scan]) begin
                winner = scan;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_idx;
        rr_nxt    = rr_ptr;
        case (state)
            IDLE: begin
                if (|ireqs_valid) begin
                    grant_nxt = winner;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (oresp_ready && oresp_last) begin
                    state_nxt = IDLE;
                    if (MODE == 0) begin
                        rr_nxt = (grant_idx == IDX_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            grant_idx <= '0;
            rr_ptr    <= '0;
        end else begin
            state     <= state_nxt;
            grant_idx <= grant_nxt;
            rr_ptr    <= rr_nxt;
        end
    end

    // kseg0/kseg1 fold onto the physical low 512 MB when translation is built in.
    always_comb begin
        addr_fwd = ireqs_addr[grant_idx];
`ifdef CBUS_ADDR_XLATE_EN
        if (addr_fwd[31:29] == 3'b100 || addr_fwd[31:29] == 3'b101) begin
            addr_fwd = {3'b000, addr_fwd[28:0]};
        end
`endif
    end

    always_comb begin
        oreq_valid    = 1'b0;
        oreq_is_write = 1'b0;
        oreq_size     = '0;
        oreq_addr     = '0;
        oreq_strobe   = '0;
        oreq_data     = '0;
        oreq_len      = '0;
        iresps_ready  = '0;
        iresps_last   = '0;
        iresps_data   = '0;
        if (state == BUSY) begin
            oreq_valid               = ireqs_valid[grant_idx];
            oreq_is_write            = ireqs_is_write[grant_idx];
            oreq_size                = ireqs_size[grant_idx];
            oreq_addr                = addr_fwd;
            oreq_strobe              = ireqs_strobe[grant_idx];
            oreq_data                = ireqs_data[grant_idx];
            oreq_len                 = ireqs_len[grant_idx];
            iresps_ready[grant_idx]  = oresp_ready;
            iresps_last[grant_idx]   = oresp_last;
            iresps_data[grant_idx]   = oresp_data;
        end
    end

    assign busy = (state == BUSY);

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Directed bench for cbus_rr_arbiter: a round-robin and a fixed-priority instance share every input.
// A burst table drives both; hand sequences cover burst lock, reset mid-burst and address translation.
module tb_cbus_rr_arbiter;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic [3:0]           ireqs_valid;
    logic [3:0]           ireqs_is_write;
    logic [3:0][1:0]      ireqs_size;
    logic [3:0][31:0]     ireqs_addr;
    logic [3:0][3:0]      ireqs_strobe;
    logic [3:0][31:0]     ireqs_data;
    logic [3:0][3:0]      ireqs_len;
    logic                 oresp_ready;
    logic                 oresp_last;
    logic [31:0]          oresp_data;

    logic [3:0]           m0_iresps_ready, m0_iresps_last, m1_iresps_ready, m1_iresps_last;
    logic [3:0][31:0]     m0_iresps_data, m1_iresps_data;
    logic                 m0_oreq_valid, m0_oreq_is_write, m1_oreq_valid, m1_oreq_is_write;
    logic [1:0]           m0_oreq_size, m1_oreq_size;
    logic [31:0]          m0_oreq_addr, m0_oreq_data, m1_oreq_addr, m1_oreq_data;
    logic [3:0]           m0_oreq_strobe, m0_oreq_len, m1_oreq_strobe, m1_oreq_len;
    logic                 m0_busy, m1_busy;
    logic [1:0]           m0_grant_idx, m1_grant_idx;

    logic [31:0]          ch_addr [4];
    int                   n_checks = 0;
    int                   n_err    = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            ireqs_addr[i]     = ch_addr[i];
            ireqs_data[i]     = 32'hD000_0000 + 32'(i);
            ireqs_is_write[i] = 1'b0;
            ireqs_size[i]     = 2'd2;
            ireqs_strobe[i]   = 4'hF;
            ireqs_len[i]      = 4'h3;
        end
    end

    cbus_rr_arbiter #(.NUM_CH(4), .MODE(0)) u_rr (
        .clk(clk), .resetn(resetn),
        .ireqs_valid(ireqs_valid), .ireqs_is_write(ireqs_is_write), .ireqs_size(ireqs_size),
        .ireqs_addr(ireqs_addr), .ireqs_strobe(ireqs_strobe), .ireqs_data(ireqs_data),
        .ireqs_len(ireqs_len),
        .iresps_ready(m0_iresps_ready), .iresps_last(m0_iresps_last), .iresps_data(m0_iresps_data),
        .oreq_valid(m0_oreq_valid), .oreq_is_write(m0_oreq_is_write), .oreq_size(m0_oreq_size),
        .oreq_addr(m0_oreq_addr), .oreq_strobe(m0_oreq_strobe), .oreq_data(m0_oreq_data),
        .oreq_len(m0_oreq_len),
        .oresp_ready(oresp_ready), .oresp_last(oresp_last), .oresp_data(oresp_data),
        .busy(m0_busy), .grant_idx(m0_grant_idx)
    );

    cbus_rr_arbiter #(.NUM_CH(4), .MODE(1)) u_fp (
        .clk(clk), .resetn(resetn),
        .ireqs_valid(ireqs_valid), .ireqs_is_write(ireqs_is_write), .ireqs_size(ireqs_size),
        .ireqs_addr(ireqs_addr), .ireqs_strobe(ireqs_strobe), .ireqs_data(ireqs_data),
        .ireqs_len(ireqs_len),
        .iresps_ready(m1_iresps_ready), .iresps_last(m1_iresps_last), .iresps_data(m1_iresps_data),
        .oreq_valid(m1_oreq_valid), .oreq_is_write(m1_oreq_is_write), .oreq_size(m1_oreq_size),
        .oreq_addr(m1_oreq_addr), .oreq_strobe(m1_oreq_strobe), .oreq_data(m1_oreq_data),
        .oreq_len(m1_oreq_len),
        .oresp_ready(oresp_ready), .oresp_last(oresp_last), .oresp_data(oresp_data),
        .busy(m1_busy), .grant_idx(m1_grant_idx)
    );

    typedef struct {
        logic [3:0] mask;
        int         beats;
        logic [1:0] eg;         // expected round-robin grant
        logic [1:0] efp;        // expected fixed-priority grant
        logic [3:0] late_mask;
        int         late_beat;  // 0 = valid mask unchanged during the burst
    } vec_t;

    vec_t tbl [13];

    function automatic logic [31:0] xl(input logic [31:0] a);
`ifdef CBUS_ADDR_XLATE_EN
        if (a[31:29] == 3'b100 || a[31:29] == 3'b101) return {3'b000, a[28:0]};
`endif
        return a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn      = 1'b0;
        ireqs_valid = '0;
        oresp_ready = 1'b0;
        oresp_last  = 1'b0;
        oresp_data  = '0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // Called just after a negedge with both arbiters idle; returns one bubble cycle later.
    task automatic do_burst(input string tag, input vec_t v);
        logic [1:0] other;
        other       = v.eg + 2'd1;
        ireqs_valid = v.mask;
        @(negedge clk);
        chk({tag, " rr grant"}, 32'(m0_grant_idx), 32'(v.eg));
        chk({tag, " fp grant"}, 32'(m1_grant_idx), 32'(v.efp));
        chk({tag, " busy"}, 32'({m0_busy, m1_busy}), 32'h3);
        chk({tag, " rr oreq_data"}, m0_oreq_data, 32'hD000_0000 + 32'(v.eg));
        for (int b = 1; b <= v.beats; b++) begin
            if (b == v.late_beat) ireqs_valid = v.late_mask;
            oresp_ready = 1'b1;
            oresp_last  = (b == v.beats);
            oresp_data  = 32'hA500_0000 + 32'(b);
            #1;
            chk({tag, " rr oreq_valid"}, 32'(m0_oreq_valid), 32'(ireqs_valid[v.eg]));
            chk({tag, " rr oreq_addr"}, m0_oreq_addr, xl(ch_addr[v.eg]));
            chk({tag, " fp oreq_addr"}, m1_oreq_addr, xl(ch_addr[v.efp]));
            chk({tag, " rr ready"}, 32'(m0_iresps_ready), 32'(4'b0001 << v.eg));
            chk({tag, " rr last"}, 32'(m0_iresps_last), (b == v.beats) ? 32'(4'b0001 << v.eg) : 32'h0);
            chk({tag, " rr rdata"}, m0_iresps_data[v.eg], oresp_data);
            chk({tag, " rr other rdata"}, m0_iresps_data[other], 32'h0);
            chk({tag, " fp ready"}, 32'(m1_iresps_ready), 32'(4'b0001 << v.efp));
            @(negedge clk);
        end
        oresp_ready = 1'b0;
        oresp_last  = 1'b0;
        oresp_data  = '0;
        #1;
        chk({tag, " bubble busy"}, 32'({m0_busy, m1_busy}), 32'h0);
        chk({tag, " bubble oreq_valid"}, 32'({m0_oreq_valid, m1_oreq_valid}), 32'h0);
        chk({tag, " bubble ready"}, 32'({m0_iresps_ready, m1_iresps_ready}), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] xa [3];
        logic [31:0] xe [3];
        vec_t        v;

        ch_addr[0] = 32'h1FC0_1000;
        ch_addr[1] = 32'h1FC0_2000;
        ch_addr[2] = 32'h1FC0_0000;
        ch_addr[3] = 32'h1FC0_3000;

        //          mask     beats eg  efp late     late_beat
        tbl[0]  = '{4'b0100, 1,  2, 2, 4'b0100, 0};  // single request, MLEN1
        tbl[1]  = '{4'b1111, 4,  3, 0, 4'b1111, 0};  // rr pointer now 3
        tbl[2]  = '{4'b1111, 4,  0, 0, 4'b1111, 0};
        tbl[3]  = '{4'b1111, 4,  1, 0, 4'b1111, 0};
        tbl[4]  = '{4'b1111, 4,  2, 0, 4'b1111, 0};
        tbl[5]  = '{4'b0011, 2,  0, 0, 4'b0011, 0};  // wraps 3 -> 0
        tbl[6]  = '{4'b0001, 1,  0, 0, 4'b0001, 0};
        tbl[7]  = '{4'b1001, 3,  3, 0, 4'b1001, 0};
        tbl[8]  = '{4'b0110, 2,  1, 1, 4'b0110, 0};
        tbl[9]  = '{4'b1010, 2,  3, 1, 4'b1010, 0};
        tbl[10] = '{4'b1000, 4,  3, 3, 4'b1010, 2};  // ch1 returns during ch3 burst
        tbl[11] = '{4'b1010, 2,  1, 1, 4'b1010, 0};
        tbl[12] = '{4'b0001, 3,  0, 0, 4'b0000, 2};  // requester drops valid mid-burst

        resetn      = 1'b0;
        ireqs_valid = '0;
        oresp_ready = 1'b0;
        oresp_last  = 1'b0;
        oresp_data  = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", 32'({m0_busy, m1_busy}), 32'h0);
        chk("reset grant", 32'({m0_grant_idx, m1_grant_idx}), 32'h0);
        chk("reset oreq_valid", 32'({m0_oreq_valid, m1_oreq_valid}), 32'h0);
        chk("reset ready", 32'({m0_iresps_ready, m0_iresps_last}), 32'h0);
        resetn = 1'b1;
        #1;

        for (int i = 0; i < 13; i++) begin
            do_burst($sformatf("vec%0d", i), tbl[i]);
        end

        // Burst lock: ch1 arrives at beat 3 of a 16-beat ch0 burst.
        do_reset();
        #1;
        v = '{4'b0001, 16, 0, 0, 4'b0011, 3};
        do_burst("lock", v);
        v = '{4'b0011, 1, 1, 0, 4'b0011, 0};
        do_burst("lock next", v);

        // Reset at beat 5 of 8 while ch2 holds the bus.
        do_reset();
        ireqs_valid = 4'b0100;
        @(negedge clk);
        chk("rst-mid grant", 32'(m0_grant_idx), 32'h2);
        for (int b = 1; b <= 4; b++) begin
            oresp_ready = 1'b1;
            oresp_data  = 32'hC000_0000 + 32'(b);
            @(negedge clk);
        end
        resetn = 1'b0;
        @(negedge clk);
        chk("rst-mid busy", 32'({m0_busy, m1_busy}), 32'h0);
        chk("rst-mid grant0", 32'({m0_grant_idx, m1_grant_idx}), 32'h0);
        chk("rst-mid oreq_valid", 32'({m0_oreq_valid, m1_oreq_valid}), 32'h0);
        chk("rst-mid ready", 32'({m0_iresps_ready, m1_iresps_ready}), 32'h0);
        chk("rst-mid rdata", m0_iresps_data[2], 32'h0);
        resetn      = 1'b1;
        oresp_ready = 1'b0;
        ireqs_valid = '0;

        // Address translation on the forwarded address.
        xa[0] = 32'hBFC0_0000;
        xa[1] = 32'h8000_1000;
        xa[2] = 32'h0000_2000;
`ifdef CBUS_ADDR_XLATE_EN
        xe[0] = 32'h1FC0_0000;
        xe[1] = 32'h0000_1000;
`else
        xe[0] = 32'hBFC0_0000;
        xe[1] = 32'h8000_1000;
`endif
        xe[2] = 32'h0000_2000;
        do_reset();
        for (int j = 0; j < 3; j++) begin
            ch_addr[0]  = xa[j];
            ireqs_valid = 4'b0001;
            @(negedge clk);
            chk($sformatf("xlate addr%0d", j), m0_oreq_addr, xe[j]);
            oresp_ready = 1'b1;
            oresp_last  = 1'b1;
            @(negedge clk);
            oresp_ready = 1'b0;
            oresp_last  = 1'b0;
            ireqs_valid = '0;
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/cbus_rr_arbiter.md
Name: cbus_rr_arbiter

Overview:
- Parametrised N-channel arbiter. Merges NUM_CH cache-bus requesters (ICache, DCache ports, uncached paths) onto the single external cbus (oreq/oresp).
- Sits between cache_manage-class blocks and the top-level oreq/oresp pair.
- Grants one whole burst at a time and locks the grant until the burst's last beat.
- Round-robin or fixed-priority selection.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8).
- MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
- IDX_W, $clog2(NUM_CH), grant index width (derived, do not override).

Ports:
- clk  input  1  clock
- resetn  input  1  synchronous active-low reset
- ireqs  input  cbus_req_t x NUM_CH  per-channel requests; index 0 = channel 0
- iresps  output  cbus_resp_t x NUM_CH  per-channel responses
- oreq  output  cbus_req_t  merged request to external bus
- oresp  input  cbus_resp_t  external bus response
- busy  output  1  high while a burst is granted
- grant_idx  output  IDX_W  currently/last granted channel

Behaviour:
- States: IDLE, BUSY.
- Reset (resetn=0 at posedge):
  - state=IDLE, busy=0, grant_idx=0, rr pointer=0.
  - oreq all-zero (valid=0); every iresps all-zero (ready=0, last=0, data=0).
- IDLE:
  - oreq.valid=0 and all iresps zero.
  - If any ireqs[i].valid, select a winner:
    - MODE 0: first valid index scanning upward from rr pointer, wrapping modulo NUM_CH.
    - MODE 1: lowest valid index.
  - Register the winner into grant_idx; go to BUSY next cycle.
  - Arbitration latency: 1 cycle from valid to oreq.valid.
- BUSY:
  - oreq = ireqs[grant_idx], forwarded combinationally each cycle (addr, data, strobe follow requester beat-by-beat).
  - iresps[grant_idx] = oresp; all other iresps zero.
  - On oresp.last=1 (with oresp.ready=1), go to IDLE next cycle. MODE 0: rr pointer = (grant_idx+1) mod NUM_CH.
  - No re-arbitration in the last cycle: one bubble cycle between bursts is guaranteed.
- Requester rules:
  - A channel holds valid and all fields stable from grant until it sees last.
  - If a requester drops valid mid-burst, the grant stays locked. oreq.valid then follows the requester (low), and the arbiter waits for last. No timeout.
- Non-granted channels: requests ignored, never see ready/last; they stay pending without loss.
- Simultaneous requests in IDLE: exactly one wins per selection rule; losers are served in later bursts.
  - MODE 0: starvation-free; any pending channel is granted within NUM_CH bursts.
  - MODE 1: no fairness guarantee.
- Wrap-around: rr pointer after channel NUM_CH-1 is 0.
- Reset mid-burst: immediate return to IDLE. oreq.valid=0 from the next cycle; the external bus is assumed reset in the same cycle.
- busy = (state==BUSY). grant_idx holds its value in IDLE until the next selection.

Optional Feature:
- Macro CBUS_ADDR_XLATE_EN.
- Defined: oreq.addr is translated from the MIPS virtual segment.
  - addr[31:29] in 3'b100 or 3'b101 (kseg0/kseg1): output {3'b000, addr[28:0]}.
  - Otherwise: passed unchanged.
  - Purely combinational on the forwarded address; no added latency.
- Undefined: oreq.addr = ireqs[grant_idx].addr untouched.

Test Plan:
- Single request: NUM_CH=4, MODE=0, ch2 valid, len=MLEN1, addr=0x1FC0_0000. Required: oreq.valid rises 1 cycle later with addr 0x1FC0_0000; iresps[2] gets ready/last; grant_idx=2; IDLE after last; rr=3.
- Round-robin: ch0..ch3 all valid continuously, each 4-beat burst, rr=0 at start. Required: grant order 0,1,2,3,0; exactly one idle cycle between bursts; no beats seen by non-granted channels.
- Fixed priority: MODE=1, ch1 and ch3 valid. Required: ch1 granted; ch3 granted only after ch1 drops valid; ch1 re-asserting during the ch3 burst does not preempt.
- Burst lock: ch0 granted for a 16-beat burst; ch1 asserts valid at beat 3. Required: oreq stays sourced from ch0 through beat 16 last; ch1 granted on the following arbitration.
- Reset mid-burst: resetn=0 at beat 5 of 8. Required: next cycle oreq.valid=0, busy=0, grant_idx=0, all iresps zero.
- CBUS_ADDR_XLATE_EN defined: ch0 request addr 0xBFC0_0000, then 0x8000_1000, then 0x0000_2000. Required: oreq.addr = 0x1FC0_0000, 0x0000_1000, 0x0000_2000 respectively.
